// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch-condition evaluator slice:
//   - RISC-V branch funct3 codes
//   - default operand width
//   - the comparison flag bundle produced by branch_cmp_core
//   - the decision bundle and the helper that turns flags into a decision
// No ports (package).
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Relations between rs1 and rs2 that every branch condition is built from.
  typedef struct packed {
    logic eq;
    logic ltS;
    logic ltU;
  } cmpFlagsT;

  // Branch decision plus the flag telling the next stage the code was bogus.
  typedef struct packed {
    logic taken;
    logic illegal;
  } decisionT;

  // Maps a funct3 code and the comparison flags onto a decision. Anything
  // that is not one of the six defined codes, including codes carrying X or
  // Z bits, falls into the default arm because case matching is exact, so an
  // unknown select yields a clean "not taken, illegal" instead of an X.
  function automatic decisionT decodeBranch(input logic [2:0] sel,
                                            input cmpFlagsT flags);
    decisionT d;
    d.taken   = 1'b0;
    d.illegal = 1'b1;
    case (sel)
      F3_BEQ: begin
        d.taken   = flags.eq;
        d.illegal = 1'b0;
      end
      F3_BNE: begin
        d.taken   = ~flags.eq;
        d.illegal = 1'b0;
      end
      F3_BLT: begin
        d.taken   = flags.ltS;
        d.illegal = 1'b0;
      end
      F3_BGE: begin
        d.taken   = ~flags.ltS;
        d.illegal = 1'b0;
      end
      F3_BLTU: begin
        d.taken   = flags.ltU;
        d.illegal = 1'b0;
      end
      F3_BGEU: begin
        d.taken   = ~flags.ltU;
        d.illegal = 1'b0;
      end
      default: begin
        d.taken   = 1'b0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// ---------------------------------------------------------------------------
// branch_cmp_core
// Purely combinational comparator. One XLEN+1-bit subtraction yields all
// three relations needed by the branch decode.
// Parameters:
//   XLEN   operand width, at least 2
// Ports:
//   srcA   in   XLEN  operand rs1
//   srcB   in   XLEN  operand rs2
//   flags  out  cmpFlagsT {eq, ltS, ltU}
// ---------------------------------------------------------------------------
module branch_cmp_core
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output cmpFlagsT        flags
);

  logic [XLEN:0] diff;
  logic          signA;
  logic          signB;

  // Zero-extending both operands by one bit makes the top bit of the
  // difference the borrow, which is exactly "srcA < srcB" unsigned.
  // For the signed relation: when the sign bits differ the negative operand
  // is the smaller one; when they match, signed and unsigned order agree, so
  // the borrow can be reused. This avoids any overflow case for MIN/MAX.
  always_comb begin
    diff      = {1'b0, srcA} - {1'b0, srcB};
    signA     = srcA[XLEN-1];
    signB     = srcB[XLEN-1];
    flags.eq  = (diff[XLEN-1:0] == '0);
    flags.ltU = diff[XLEN];
    flags.ltS = (signA ^ signB) ? signA : diff[XLEN];
  end

endmodule

// File: rtl/branch_operator.sv
// ---------------------------------------------------------------------------
// branch_operator
// RISC-V branch-condition evaluator. Compares rs1/rs2 according to the
// branch funct3 code and produces the branch-taken decision for PC select,
// plus a registered copy and an illegal-code flag for the next stage.
// Parameters:
//   XLEN      operand width, at least 2 (default 64)
// Ports:
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous active-high reset (registers only)
//   SrcA      in   XLEN  operand rs1
//   SrcB      in   XLEN  operand rs2
//   InstSel   in   3     branch funct3
//   result    out  1     branch taken
//   Illegal   out  1     InstSel is not a defined branch code
//   ResultQ   out  1     result registered on clk
//   IllegalQ  out  1     Illegal registered on clk
// Build option:
//   BRANCH_OP_REG_OUT_EN  when defined, result/Illegal are driven from the
//                         registered values (1-cycle latency, reset to 0);
//                         otherwise they are combinational.
// ---------------------------------------------------------------------------
module branch_operator
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      InstSel,
  output logic            result,
  output logic            Illegal,
  output logic            ResultQ,
  output logic            IllegalQ
);

  cmpFlagsT flags;
  decisionT decision;

  branch_cmp_core #(
    .XLEN (XLEN)
  ) cmpCore (
    .srcA  (SrcA),
    .srcB  (SrcB),
    .flags (flags)
  );

  // Same-cycle decode of the funct3 code against the comparison flags.
  always_comb begin
    decision = decodeBranch(InstSel, flags);
  end

  // Pipeline copy for the next stage. Reset only clears these registers;
  // on the first edge after release they simply pick up whatever the
  // combinational decode currently says.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ResultQ  <= 1'b0;
      IllegalQ <= 1'b0;
    end else begin
      ResultQ  <= decision.taken;
      IllegalQ <= decision.illegal;
    end
  end

`ifdef BRANCH_OP_REG_OUT_EN
  // Registered-output build: the primary outputs mirror the pipeline copy,
  // trading a cycle of latency for a clean flop-driven timing path.
  always_comb begin
    result  = ResultQ;
    Illegal = IllegalQ;
  end
`else
  // Default build: primary outputs come straight from the decode so PC
  // select sees the decision in the same cycle.
  always_comb begin
    result  = decision.taken;
    Illegal = decision.illegal;
  end
`endif

endmodule

// File: tb/tb_branch_operator.sv
// ---------------------------------------------------------------------------
// tb_branch_operator
// Self-checking bench for branch_operator (XLEN=64). Expected decisions come
// from a behavioural model using native signed/unsigned compares, are queued
// when stimulus is driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_branch_operator;

  localparam int XLEN = 64;

  typedef struct {
    logic res;
    logic ill;
  } expT;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [2:0]      InstSel;
  logic            result;
  logic            Illegal;
  logic            ResultQ;
  logic            IllegalQ;

  int assertCount;
  int failCount;

  expT combQ[$];
  expT regQ[$];

  logic prevRes;
  logic prevIll;

  branch_operator #(
    .XLEN (XLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .InstSel  (InstSel),
    .result   (result),
    .Illegal  (Illegal),
    .ResultQ  (ResultQ),
    .IllegalQ (IllegalQ)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of the branch decision.
  function automatic expT model(input logic [2:0] sel, input logic [63:0] a,
                                input logic [63:0] b);
    expT e;
    e.res = 1'b0;
    e.ill = 1'b0;
    case (sel)
      3'b000: e.res = (a == b);
      3'b001: e.res = (a != b);
      3'b100: e.res = ($signed(a) < $signed(b));
      3'b101: e.res = ($signed(a) >= $signed(b));
      3'b110: e.res = (a < b);
      3'b111: e.res = (a >= b);
      default: begin
        e.res = 1'b0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Drives one vector after a falling edge, checks the primary outputs
  // before the next rising edge and the registered copy just after it.
  task automatic applyStimulus(input string tag, input logic [2:0] sel,
                               input logic [63:0] a, input logic [63:0] b);
    expT e;
    expT got;
    @(negedge clk);
    InstSel = sel;
    SrcA    = a;
    SrcB    = b;
    e = model(sel, a, b);
    combQ.push_back(e);
    regQ.push_back(e);
    #1;
    got = combQ.pop_front();
`ifdef BRANCH_OP_REG_OUT_EN
    checkOutput({tag, ".resHold"}, {63'd0, result}, {63'd0, prevRes});
    checkOutput({tag, ".illHold"}, {63'd0, Illegal}, {63'd0, prevIll});
`else
    checkOutput({tag, ".res"}, {63'd0, result}, {63'd0, got.res});
    checkOutput({tag, ".ill"}, {63'd0, Illegal}, {63'd0, got.ill});
`endif
    @(posedge clk);
    #1;
    got = regQ.pop_front();
    checkOutput({tag, ".resQ"}, {63'd0, ResultQ}, {63'd0, got.res});
    checkOutput({tag, ".illQ"}, {63'd0, IllegalQ}, {63'd0, got.ill});
`ifdef BRANCH_OP_REG_OUT_EN
    checkOutput({tag, ".resReg"}, {63'd0, result}, {63'd0, got.res});
`endif
    prevRes = got.res;
    prevIll = got.ill;
  endtask

  // Main sequence.
  initial begin
    logic [2:0]  probe;
    logic [63:0] minInt;
    logic [63:0] maxInt;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rs;

    assertCount = 0;
    failCount   = 0;
    prevRes     = 1'b0;
    prevIll     = 1'b0;
    rst         = 1'b1;
    SrcA        = '0;
    SrcB        = '0;
    InstSel     = 3'b010;
    minInt      = 64'h8000_0000_0000_0000;
    maxInt      = 64'h7FFF_FFFF_FFFF_FFFF;

    #2;
    checkOutput("reset.resQ", {63'd0, ResultQ}, 64'd0);
    checkOutput("reset.illQ", {63'd0, IllegalQ}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unknown select: only observable on a four-state simulator.
    probe = 3'bzzz;
    if ($isunknown(probe)) begin
      @(negedge clk);
      InstSel = probe;
      #1;
`ifndef BRANCH_OP_REG_OUT_EN
      checkOutput("zzz.res", {63'd0, result}, 64'd0);
      checkOutput("zzz.ill", {63'd0, Illegal}, 64'd1);
`endif
      @(posedge clk);
      #1;
      checkOutput("zzz.illQ", {63'd0, IllegalQ}, 64'd1);
      prevRes = 1'b0;
      prevIll = 1'b1;
    end

    applyStimulus("beq5_0",  3'b000, 64'd5,  64'd0);
    applyStimulus("bne0_5",  3'b001, 64'd0,  64'd5);
    applyStimulus("beq10_5", 3'b000, 64'd10, 64'd5);
    applyStimulus("bne5_10", 3'b001, 64'd5,  64'd10);

    applyStimulus("blt_m1_1",  3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    applyStimulus("bltu_m1_1", 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    applyStimulus("bge_m1_1",  3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    applyStimulus("bgeu_m1_1", 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);

    applyStimulus("eq.beq",  3'b000, minInt, minInt);
    applyStimulus("eq.bne",  3'b001, minInt, minInt);
    applyStimulus("eq.blt",  3'b100, minInt, minInt);
    applyStimulus("eq.bge",  3'b101, minInt, minInt);
    applyStimulus("eq.bltu", 3'b110, minInt, minInt);
    applyStimulus("eq.bgeu", 3'b111, minInt, minInt);

    applyStimulus("blt_min_max",  3'b100, minInt, maxInt);
    applyStimulus("bge_max_min",  3'b101, maxInt, minInt);
    applyStimulus("bltu_min_max", 3'b110, minInt, maxInt);

    applyStimulus("ill010", 3'b010, 64'd0, 64'd0);
    applyStimulus("ill011", 3'b011, 64'd0, 64'd0);

    for (int i = 0; i < 24; i++) begin
      rs = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = (i % 4 == 0) ? ra : {$urandom, $urandom};
      if (i % 5 == 1) begin
        rb = ra ^ 64'h8000_0000_0000_0000;
      end
      applyStimulus($sformatf("rand%0d", i), rs, ra, rb);
    end

    // Asynchronous reset while the registered decision is 1.
    applyStimulus("preRst", 3'b000, 64'd7, 64'd7);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst.resQ", {63'd0, ResultQ}, 64'd0);
`ifdef BRANCH_OP_REG_OUT_EN
    checkOutput("asyncRst.res", {63'd0, result}, 64'd0);
`else
    checkOutput("asyncRst.res", {63'd0, result}, 64'd1);
`endif
    @(posedge clk);
    #1;
    checkOutput("rstHold.resQ", {63'd0, ResultQ}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstRelease.resQ", {63'd0, ResultQ}, 64'd1);
    prevRes = 1'b1;
    prevIll = 1'b0;

    applyStimulus("post.bne0_5", 3'b001, 64'd0, 64'd5);

    if (combQ.size() != 0 || regQ.size() != 0) begin
      checkOutput("queueDrain", 64'(combQ.size() + regQ.size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
